// File: rtl/seg_frame_rx.sv
// seg_frame_rx: receiver for a multiplexed seven-segment display bus.
// Synchronizes SEGA..SEGG/SEGDP/SEGCLK/SEGCAT into SYSCLK. Each
// synchronized SEGCLK falling edge samples the segment and cathode lines.
// The sampled pattern is decoded back to a 4-bit value. Once every digit
// slot of a scan has been seen, the decoded frame is published with a
// single-cycle FRAME_STB.
// Optional feature: define SEG_FRAME_RX_HEX_EN so that the A-F patterns
// decode as valid values 10-15. Without it, those patterns are invalid
// samples.
module seg_frame_rx #(
    parameter int NUM_DIGITS  = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    SYSCLK,
    input  logic                    RST,
    input  logic                    SEGA,
    input  logic                    SEGB,
    input  logic                    SEGC,
    input  logic                    SEGD,
    input  logic                    SEGE,
    input  logic                    SEGF,
    input  logic                    SEGG,
    input  logic                    SEGDP,
    input  logic                    SEGCLK,
    input  logic [NUM_DIGITS-1:0]   SEGCAT,
    output logic [4*NUM_DIGITS-1:0] DIGITS,
    output logic [NUM_DIGITS-1:0]   DP,
    output logic [NUM_DIGITS-1:0]   BLANK,
    output logic                    FRAME_STB,
    output logic                    FRAME_ERR
);

    // Bundle layout (MSB first): pattern A..G, DP, SEGCLK, cathodes.
    localparam int LW = 9 + NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int NW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EMIT
    } state_t;

    // Decode result is {invalid, blank, value[3:0]}.
    function automatic logic [5:0] f_decode(input logic [6:0] p);
        logic [5:0] d;
        d = 6'b00_0000;
        case (p)
            7'h7E: d[3:0] = 4'd0;
            7'h30: d[3:0] = 4'd1;
            7'h6D: d[3:0] = 4'd2;
            7'h79: d[3:0] = 4'd3;
            7'h33: d[3:0] = 4'd4;
            7'h5B: d[3:0] = 4'd5;
            7'h5F: d[3:0] = 4'd6;
            7'h70: d[3:0] = 4'd7;
            7'h7F: d[3:0] = 4'd8;
            7'h7B: d[3:0] = 4'd9;
            7'h00: d[4]   = 1'b1;
`ifdef SEG_FRAME_RX_HEX_EN
            7'h77: d[3:0] = 4'hA;
            7'h1F: d[3:0] = 4'hB;
            7'h4E: d[3:0] = 4'hC;
            7'h3D: d[3:0] = 4'hD;
            7'h4F: d[3:0] = 4'hE;
            7'h47: d[3:0] = 4'hF;
`endif
            default: d[5] = 1'b1;
        endcase
        return d;
    endfunction

    logic [LW-1:0]           r_sync [SYNC_STAGES];
    logic                    r_clk_prev;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic                    r_err_acc;
    logic [4*NUM_DIGITS-1:0] r_sh_val;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank;
    state_t                  r_state;

    logic [LW-1:0]           w_raw;
    logic [LW-1:0]           w_synced;
    logic [6:0]              w_pat;
    logic                    w_dp_in;
    logic                    w_clk;
    logic [NUM_DIGITS-1:0]   w_cat;
    logic                    w_fall;
    logic [5:0]              w_dec;
    logic [NW-1:0]           w_n_low;
    logic [IW-1:0]           w_low_idx;
    logic                    w_one_low;
    logic                    w_load;
    logic [NUM_DIGITS-1:0]   w_seen_next;
    logic                    w_err_next;
    state_t                  w_state_next;

    assign w_raw     = {SEGA, SEGB, SEGC, SEGD, SEGE, SEGF, SEGG, SEGDP, SEGCLK, SEGCAT};
    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign w_pat     = w_synced[LW-1 -: 7];
    assign w_dp_in   = w_synced[NUM_DIGITS+1];
    assign w_clk     = w_synced[NUM_DIGITS];
    assign w_cat     = w_synced[NUM_DIGITS-1:0];
    assign w_fall    = r_clk_prev & ~w_clk;
    assign w_dec     = f_decode(w_pat);
    assign w_one_low = (w_n_low == NW'(1));
    assign FRAME_STB = (r_state == S_EMIT);

    // Synchronizer chain for every display line, plus the SEGCLK history bit.
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            r_clk_prev <= 1'b0;
        end else begin
            r_sync[0] <= w_raw;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            r_clk_prev <= w_clk;
        end
    end

    // Count the low cathodes and remember which one was low.
    always_comb begin
        w_n_low   = '0;
        w_low_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!w_cat[i]) begin
                w_n_low   = w_n_low + NW'(1);
                w_low_idx = IW'(i);
            end
        end
    end

    // Seen/error bookkeeping: a completed frame clears first, then the sample applies.
    always_comb begin
        w_seen_next = w_load ? '0 : r_seen;
        w_err_next  = w_load ? 1'b0 : r_err_acc;
        if (w_fall) begin
            if (w_one_low) begin
                w_seen_next[w_low_idx] = 1'b1;
                w_err_next             = w_err_next | w_dec[5];
            end else if (w_n_low != '0) begin
                w_err_next = 1'b1;
            end
        end
    end

    // Shadow slot write plus seen/error accumulator registers.
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            r_seen     <= '0;
            r_err_acc  <= 1'b0;
            r_sh_val   <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= '0;
        end else begin
            r_seen    <= w_seen_next;
            r_err_acc <= w_err_next;
            if (w_fall && w_one_low) begin
                r_sh_val[{w_low_idx, 2'b00} +: 4] <= w_dec[3:0];
                r_sh_dp[w_low_idx]                <= w_dp_in;
                r_sh_blank[w_low_idx]             <= w_dec[4];
            end
        end
    end

    // Frame FSM state register.
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Frame FSM next state; a full seen set publishes and enters EMIT.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        if (r_seen == '1) begin
            w_load       = 1'b1;
            w_state_next = S_EMIT;
        end else begin
            case (r_state)
                S_IDLE:    if (r_seen != '0) w_state_next = S_COLLECT;
                S_COLLECT: if (r_seen == '0) w_state_next = S_IDLE;
                S_EMIT:    w_state_next = (r_seen != '0) ? S_COLLECT : S_IDLE;
                default:   w_state_next = S_IDLE;
            endcase
        end
    end

    // Published frame registers; hold between strobes.
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            DIGITS    <= '0;
            DP        <= '0;
            BLANK     <= '1;
            FRAME_ERR <= 1'b0;
        end else if (w_load) begin
            DIGITS    <= r_sh_val;
            DP        <= r_sh_dp;
            BLANK     <= r_sh_blank;
            FRAME_ERR <= r_err_acc;
        end
    end

endmodule

// File: tb/tb_seg_frame_rx.sv
// Bench for seg_frame_rx: scans driven at display-bus level, frames compared
// against a sample-level reference model of the receiver.
module tb_seg_frame_rx;
    localparam int ND = 5;
    localparam int SS = 2;

    logic SYSCLK = 1'b0;
    logic RST = 1'b1;
    logic SEGA = 0, SEGB = 0, SEGC = 0, SEGD = 0, SEGE = 0, SEGF = 0, SEGG = 0;
    logic SEGDP = 0, SEGCLK = 1'b1;
    logic [ND-1:0] SEGCAT = '1;
    logic [4*ND-1:0] DIGITS;
    logic [ND-1:0] DP, BLANK;
    logic FRAME_STB, FRAME_ERR;

    seg_frame_rx #(.NUM_DIGITS(ND), .SYNC_STAGES(SS)) dut (
        .SYSCLK(SYSCLK), .RST(RST),
        .SEGA(SEGA), .SEGB(SEGB), .SEGC(SEGC), .SEGD(SEGD),
        .SEGE(SEGE), .SEGF(SEGF), .SEGG(SEGG), .SEGDP(SEGDP),
        .SEGCLK(SEGCLK), .SEGCAT(SEGCAT),
        .DIGITS(DIGITS), .DP(DP), .BLANK(BLANK),
        .FRAME_STB(FRAME_STB), .FRAME_ERR(FRAME_ERR)
    );

    always #5 SYSCLK = ~SYSCLK;

    int cyc = 0;
    int last_fall = 0;
    int n_checks = 0;
    int n_pass = 0;

    // Frame word: {latency[7:0], DIGITS, DP, BLANK, FRAME_ERR}
    logic [38:0] obs_q[$];
    logic [38:0] exp_q[$];

    always @(posedge SYSCLK) cyc <= cyc + 1;

    always @(negedge SYSCLK)
        if (FRAME_STB) obs_q.push_back({8'(cyc - last_fall), DIGITS, DP, BLANK, FRAME_ERR});

    // Segment patterns indexed by the value they show.
    logic [6:0] pat_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
`ifdef SEG_FRAME_RX_HEX_EN
    localparam int NVALID = 16;
`else
    localparam int NVALID = 10;
`endif

    // Reference model: per-slot contents plus seen set and error flag.
    int      m_val [ND];
    bit      m_dp  [ND];
    bit      m_bl  [ND];
    bit [ND-1:0] m_seen = '0;
    bit      m_err = 0;

    task automatic model_reset();
        m_seen = '0;
        m_err  = 0;
    endtask

    task automatic model_sample(input logic [ND-1:0] cat, input logic [6:0] pat, input bit dp);
        int lows, idx, v;
        bit bl, inv;
        logic [4*ND-1:0] dg;
        logic [ND-1:0] dpv, blv;
        lows = 0; idx = 0;
        for (int i = 0; i < ND; i++) if (!cat[i]) begin lows++; idx = i; end
        v = 0; bl = 0; inv = 1;
        if (pat == 7'h00) begin bl = 1; inv = 0; end
        else for (int k = 0; k < NVALID; k++) if (pat_tbl[k] == pat) begin v = k; inv = 0; end
        if (lows == 1) begin
            m_val[idx] = v; m_dp[idx] = dp; m_bl[idx] = bl;
            m_seen[idx] = 1'b1;
            m_err = m_err | inv;
        end else if (lows > 1) begin
            m_err = 1;
        end
        if (&m_seen) begin
            for (int i = 0; i < ND; i++) begin
                dg[4*i +: 4] = 4'(m_val[i]);
                dpv[i] = m_dp[i];
                blv[i] = m_bl[i];
            end
            exp_q.push_back({8'(SS + 2), dg, dpv, blv, m_err});
            m_seen = '0;
            m_err  = 0;
        end
    endtask

    // One display slot: lines change with SEGCLK rise, sampled at the fall.
    task automatic scan(input logic [ND-1:0] cat, input logic [6:0] pat, input bit dp);
        @(negedge SYSCLK);
        SEGCLK = 1'b1;
        {SEGA, SEGB, SEGC, SEGD, SEGE, SEGF, SEGG} = pat;
        SEGDP  = dp;
        SEGCAT = cat;
        repeat (5) @(negedge SYSCLK);
        SEGCLK = 1'b0;
        last_fall = cyc;
        repeat (5) @(negedge SYSCLK);
        model_sample(cat, pat, dp);
    endtask

    function automatic logic [ND-1:0] cat_of(input int d);
        return ~(ND'(1) << d);
    endfunction

    task automatic test_reset();
        logic [38:0] o, e;
        RST = 1'b1;
        repeat (3) @(negedge SYSCLK);
        RST = 1'b0;
        @(negedge SYSCLK);
        n_checks++; if (DIGITS !== 20'h0) $display("FAIL reset_digits got=%h exp=00000", DIGITS); else n_pass++;
        n_checks++; if (DP !== 5'h00) $display("FAIL reset_dp got=%h exp=00", DP); else n_pass++;
        n_checks++; if (BLANK !== 5'h1F) $display("FAIL reset_blank got=%h exp=1f", BLANK); else n_pass++;
        n_checks++; if (FRAME_STB !== 1'b0) $display("FAIL reset_stb got=%b exp=0", FRAME_STB); else n_pass++;
        n_checks++; if (FRAME_ERR !== 1'b0) $display("FAIL reset_err got=%b exp=0", FRAME_ERR); else n_pass++;
        for (int n = 0; n < 6; n++) scan('1, pat_tbl[n], 1'b0);
        n_checks++; if (obs_q.size() != 0) $display("FAIL idle_strobes got=%0d exp=0", obs_q.size()); else n_pass++;
        n_checks++; if (BLANK !== 5'h1F || DIGITS !== 20'h0) $display("FAIL idle_hold got=%h/%h exp=1f/00000", BLANK, DIGITS); else n_pass++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_basic_scan();
        logic [38:0] o, e;
        for (int d = 0; d < ND; d++) scan(cat_of(d), pat_tbl[d], d == 2);
        n_checks++; if (DIGITS !== 20'h43210) $display("FAIL basic_digits got=%h exp=43210", DIGITS); else n_pass++;
        n_checks++; if (DP !== 5'h04 || BLANK !== 5'h00 || FRAME_ERR !== 1'b0)
            $display("FAIL basic_flags got=%h/%h/%b exp=04/00/0", DP, BLANK, FRAME_ERR); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL basic_frame got=%h exp=%h", o, e); else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_hex_digit();
        logic [38:0] o, e;
        for (int d = 0; d < ND; d++) scan(cat_of(d), (d == 4) ? 7'h77 : pat_tbl[d], 1'b0);
`ifdef SEG_FRAME_RX_HEX_EN
        n_checks++; if (DIGITS[19:16] !== 4'hA || FRAME_ERR !== 1'b0)
            $display("FAIL hex_digit got=%h/%b exp=a/0", DIGITS[19:16], FRAME_ERR); else n_pass++;
`else
        n_checks++; if (DIGITS[19:16] !== 4'h0 || FRAME_ERR !== 1'b1)
            $display("FAIL hex_digit got=%h/%b exp=0/1", DIGITS[19:16], FRAME_ERR); else n_pass++;
`endif
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL hex_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL hex_frame got=%h exp=%h", o, e); else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_multi_low();
        logic [38:0] o, e;
        scan(cat_of(0), pat_tbl[5], 1'b0);
        scan(cat_of(1), pat_tbl[6], 1'b0);
        scan(5'b11100, pat_tbl[8], 1'b1);
        for (int d = 2; d < ND; d++) scan(cat_of(d), pat_tbl[d + 5], 1'b0);
        n_checks++; if (FRAME_ERR !== 1'b1) $display("FAIL multi_low_err got=%b exp=1", FRAME_ERR); else n_pass++;
        for (int d = 0; d < ND; d++) scan(cat_of(d), pat_tbl[9 - d], 1'b0);
        n_checks++; if (FRAME_ERR !== 1'b0) $display("FAIL clean_after_err got=%b exp=0", FRAME_ERR); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL multi_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL multi_frame got=%h exp=%h", o, e); else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_overwrite();
        logic [38:0] o, e;
        scan(cat_of(1), 7'h30, 1'b0);
        scan('1, 7'h7E, 1'b1);
        scan(cat_of(0), 7'h7E, 1'b0);
        scan(cat_of(1), 7'h7F, 1'b0);
        scan('1, 7'h00, 1'b0);
        for (int d = 2; d < ND; d++) scan(cat_of(d), pat_tbl[d], 1'b0);
        n_checks++; if (DIGITS[7:4] !== 4'h8) $display("FAIL overwrite_digit got=%h exp=8", DIGITS[7:4]); else n_pass++;
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL overwrite_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL overwrite_frame got=%h exp=%h", o, e); else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [38:0] o, e;
        for (int d = 0; d < 3; d++) scan(cat_of(d), pat_tbl[d + 1], 1'b1);
        @(negedge SYSCLK);
        RST = 1'b1;
        @(negedge SYSCLK);
        n_checks++; if (DIGITS !== 20'h0 || DP !== 5'h00 || BLANK !== 5'h1F || FRAME_ERR !== 1'b0 || FRAME_STB !== 1'b0)
            $display("FAIL midreset_outputs got=%h/%h/%h/%b/%b exp=00000/00/1f/0/0", DIGITS, DP, BLANK, FRAME_ERR, FRAME_STB);
        else n_pass++;
        @(negedge SYSCLK);
        RST = 1'b0;
        model_reset();
        scan(cat_of(3), pat_tbl[3], 1'b0);
        scan(cat_of(4), pat_tbl[4], 1'b0);
        n_checks++; if (obs_q.size() != 0) $display("FAIL midreset_early_strobe got=%0d exp=0", obs_q.size()); else n_pass++;
        for (int d = 0; d < 3; d++) scan(cat_of(d), pat_tbl[d], 1'b0);
        n_checks++; if (obs_q.size() != exp_q.size() || exp_q.size() != 1)
            $display("FAIL midreset_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL midreset_frame got=%h exp=%h", o, e); else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [38:0] o, e;
        logic [ND-1:0] cat;
        logic [6:0] pat;
        int r, a, b;
        for (int n = 0; n < 90; n++) begin
            r = $urandom_range(0, 99);
            if (r < 72) cat = cat_of($urandom_range(0, ND - 1));
            else if (r < 86) cat = '1;
            else begin
                a = $urandom_range(0, ND - 1);
                b = (a + 1 + $urandom_range(0, ND - 2)) % ND;
                cat = ~((ND'(1) << a) | (ND'(1) << b));
            end
            r = $urandom_range(0, 19);
            if (r < 16) pat = pat_tbl[r];
            else if (r < 18) pat = 7'h00;
            else pat = 7'($urandom_range(1, 127));
            scan(cat, pat, 1'($urandom_range(0, 1)));
        end
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL random_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL random_frame got=%h exp=%h", o, e); else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_hex_digit();
        test_multi_low();
        test_overwrite();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_frame_rx.md
# seg_frame_rx

Display-bus receiver that reconstructs what the stopwatch's multiplexed seven-segment driver is showing. It samples the segment, decimal-point, cathode and segment-clock lines in the SYSCLK domain and decodes each segment pattern back to a 4-bit digit value. It assembles one full scan of all digits into a frame and presents that frame with a one-cycle strobe. It sits next to the stopwatch in self-checking benches and on-board loopback builds, as the consumer end of the SEGA..SEGDP/SEGCLK/SEGCAT interface.

## Interface
- NUM_DIGITS, 5, digits per scan; width of SEGCAT and of the per-digit outputs.
- SYNC_STAGES, 2, synchronizer flops on every display input (minimum 2).

Ports:
- SYSCLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- SEGA..SEGG  in  1 each  segment lines, active-high.
- SEGDP  in  1  decimal point, active-high.
- SEGCLK  in  1  display scan clock from the driver.
- SEGCAT  in  NUM_DIGITS  digit select, active-low, one-hot; bit i selects digit i.
- DIGITS  out  4*NUM_DIGITS  decoded values; digit i at [4i+3:4i].
- DP  out  NUM_DIGITS  decimal point per digit.
- BLANK  out  NUM_DIGITS  digit showed all segments off.
- FRAME_STB  out  1  one-cycle pulse: DIGITS/DP/BLANK/FRAME_ERR just updated.
- FRAME_ERR  out  1  the frame just delivered contained an invalid sample.

## Operation
- All SEGx, SEGDP, SEGCLK and SEGCAT pass through SYNC_STAGES flops. The driver changes lines on SEGCLK rising, so sampling happens on the synchronized SEGCLK falling edge.
- Pattern P = {A,B,C,D,E,F,G} with A as MSB.
- Digit decode: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B.
- Hex decode: A=77, b=1F, C=4E, d=3D, E=4F, F=47 (see Configuration).
- P=00 decodes as value 0 with blank=1.
- Any other P decodes as value 0 with blank=0, and raises the sample-invalid flag.
- Cathode classification at each sample:
  - Exactly one bit low (index i): write the value, DP and blank into shadow slot i, set seen[i], and OR the sample-invalid flag into err_acc.
  - All bits high: inter-digit blanking; sample ignored, no state change.
  - Two or more bits low: sample discarded, err_acc set.
- A slot written twice before frame completion is overwritten; the latest sample wins.
- Frame completion happens when seen becomes all-ones, including the sample that sets the last bit. The next cycle:
  - Shadow copies to DIGITS/DP/BLANK.
  - FRAME_ERR is set to err_acc.
  - FRAME_STB=1.
  - seen and err_acc are cleared.
- Outputs hold between strobes. FRAME_ERR is valid with FRAME_STB and held until the next strobe.
- States: IDLE (seen=0), COLLECT (seen partial), EMIT (single cycle, strobe), then back to IDLE.

## Timing
- Reset values: DIGITS=0, DP=0, BLANK=all-ones, FRAME_STB=0, FRAME_ERR=0. Synchronizers, shadow, seen and err_acc all cleared.
- The edge detector compares the last two synchronized SEGCLK values. A falling edge at the input pin is detected SYNC_STAGES+1 cycles later; the sample registers on that cycle.
- FRAME_STB is asserted the cycle after the completing sample registers: SYNC_STAGES+2 cycles after the final SEGCLK fall.
- Required input timing: each SEGCLK half-period is at least SYNC_STAGES+2 SYSCLK cycles. Segment and cathode lines are stable from SEGCLK rise to the following fall.
- A new sample arriving in the EMIT cycle is applied to the freshly cleared seen/err_acc and counts toward the next frame.
- RST asserted mid-frame clears everything immediately. The first strobe after release requires a full new scan.

## Configuration
- SEG_FRAME_RX_HEX_EN defined: patterns A–F decode to values 10–15 and are valid.
- Undefined: only 0–9 and blank are valid; the A–F patterns are treated as invalid (value 0, err_acc set).

## Test plan
- Reset then idle SEGCLK -> FRAME_STB never pulses, DIGITS=0, BLANK=1F, FRAME_ERR=0.
- Scan digits 0..4 with patterns 7E,30,6D,79,33 and DP on digit 2 -> one FRAME_STB; DIGITS=0x43210, DP=04, BLANK=00, FRAME_ERR=0, exactly SYNC_STAGES+2 cycles after the 5th SEGCLK fall.
- Same scan with digit 4 driven 77 -> with the macro, DIGITS[19:16]=0xA and FRAME_ERR=0; without it, 0x0 and FRAME_ERR=1.
- Insert SEGCAT=11100 (two low) mid-scan -> sample dropped; that frame's FRAME_ERR=1; the next clean frame has FRAME_ERR=0.
- Scan digit 1 twice (30 then 7F) before finishing the frame -> DIGITS[7:4]=8; insert all-high cathode slots -> no effect.
- Assert RST after 3 of 5 digits -> outputs return to reset values; the strobe appears only after 5 further fresh digits.
